// File: rtl/sha256_pkg.sv
// Shared types and constants for the sha256 message padder.
// Slot numbering follows block word order: slot 0 lands in block_o[511:480].
package sha256_pkg;

    typedef enum logic [1:0] {
        S_LOAD,
        S_PAD,
        S_EMIT
    } state_e;

    localparam logic [7:0]  PAD_BYTE        = 8'h80;
    localparam int          WORDS_PER_BLOCK = 16;
    localparam logic [3:0]  LAST_SLOT       = 4'(WORDS_PER_BLOCK - 1);
    localparam logic [3:0]  LEN_HI_SLOT     = 4'd14;
    localparam logic [3:0]  LEN_LO_SLOT     = 4'd15;
    localparam logic [31:0] PAD_WORD        = {PAD_BYTE, 24'h000000};

    // A last word can carry at most four bytes; larger counts mean a full word.
    function automatic logic [2:0] clamp_bytes(input logic [2:0] nbytes);
        return (nbytes > 3'd4) ? 3'd4 : nbytes;
    endfunction

endpackage

// File: rtl/sha256_pad_word.sv
// Merges the final message word with the 0x80 marker byte.
// Bytes below nbytes_i pass through, byte nbytes_i becomes 0x80, the rest are zero.
module sha256_pad_word
    import sha256_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [2:0]  nbytes_i,
    output logic [31:0] word_o
);

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign word_o[31-8*i -: 8] = (3'(i) < nbytes_i)  ? data_i[31-8*i -: 8] :
                                     (3'(i) == nbytes_i) ? PAD_BYTE :
                                                           8'h00;
    end

endmodule

// File: rtl/sha256_padder.sv
// FIPS 180-4 message padder: packs 32-bit words into 512-bit blocks, adds the
// 0x80 marker, zero fill and the 64-bit bit length, and flags the final block.
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  in_data,
    input  logic         in_valid,
    input  logic         in_last,
    input  logic [2:0]   in_bytes,
    output logic         in_ready,
    output logic [511:0] block_o,
    output logic         block_valid_o,
    input  logic         block_ready_i,
    output logic         block_last_o
);

    state_e             state_q, state_d;
    logic [3:0]         widx_q, widx_d;
    logic [LEN_W-1:0]   bitcnt_q, bitcnt_d;
    logic               final_q, final_d;
    logic               pend80_q, pend80_d;
    logic               pad_q, pad_d;
    logic               len_blk_q, len_blk_d;
    logic [31:0]        blk_q [WORDS_PER_BLOCK];
    logic [31:0]        blk_d [WORDS_PER_BLOCK];

    logic [2:0]         nbytes;
    logic [31:0]        data_word;
    logic [31:0]        fill_word;
    logic [63:0]        len64;
    logic [4:0]         mark_slot;
    logic               accept;

    assign nbytes = clamp_bytes(in_bytes);

    sha256_pad_word u_pad_word (
        .data_i   (in_data),
        .nbytes_i (nbytes),
        .word_o   (data_word)
    );

    assign in_ready      = rst && (state_q == S_LOAD);
    assign accept        = in_valid && in_ready;
    assign block_valid_o = (state_q == S_EMIT);
    assign block_last_o  = block_valid_o && final_q;

    always_comb begin
        block_o = '0;
        for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
            block_o[511-32*i -: 32] = blk_q[i];
        end
    end

    // Word written into the current slot while padding.
    always_comb begin
        len64     = 64'(bitcnt_q);
        fill_word = '0;
        if (pend80_q) begin
            fill_word = PAD_WORD;
        end else if (len_blk_q && widx_q == LEN_HI_SLOT) begin
            fill_word = len64[63:32];
        end else if (len_blk_q && widx_q == LEN_LO_SLOT) begin
            fill_word = len64[31:0];
        end
    end

    // A full last word pushes the marker into the following slot; a slot index
    // of 16 means the marker spills into the next block.
    assign mark_slot = {1'b0, widx_q} + ((nbytes == 3'd4) ? 5'd1 : 5'd0);

    always_comb begin
        state_d   = state_q;
        widx_d    = widx_q;
        bitcnt_d  = bitcnt_q;
        final_d   = final_q;
        pend80_d  = pend80_q;
        pad_d     = pad_q;
        len_blk_d = len_blk_q;
        blk_d     = blk_q;

        unique case (state_q)
            S_LOAD: begin
                if (accept) begin
                    if (!in_last) begin
                        blk_d[widx_q] = in_data;
                        bitcnt_d      = bitcnt_q + LEN_W'(32);
                    end else begin
                        blk_d[widx_q] = data_word;
                        bitcnt_d      = bitcnt_q + LEN_W'({nbytes, 3'b000});
                        pend80_d      = (nbytes == 3'd4);
                        pad_d         = 1'b1;
                        len_blk_d     = (mark_slot < {1'b0, LEN_HI_SLOT});
                        state_d       = S_PAD;
                    end
                    if (widx_q == LAST_SLOT) begin
                        state_d = S_EMIT;
                        final_d = 1'b0;
                    end else begin
                        widx_d = widx_q + 4'd1;
                    end
                end
            end
            S_PAD: begin
                blk_d[widx_q] = fill_word;
                pend80_d      = 1'b0;
                if (widx_q == LAST_SLOT) begin
                    state_d = S_EMIT;
                    final_d = len_blk_q;
                end else begin
                    widx_d = widx_q + 4'd1;
                end
            end
            S_EMIT: begin
                if (block_ready_i) begin
                    widx_d = '0;
                    if (final_q) begin
                        state_d  = S_LOAD;
                        bitcnt_d = '0;
                        final_d  = 1'b0;
                        pad_d    = 1'b0;
                    end else if (pad_q) begin
                        // Overflow block: always carries the length.
                        state_d   = S_PAD;
                        len_blk_d = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_LOAD;
            widx_q    <= '0;
            bitcnt_q  <= '0;
            final_q   <= 1'b0;
            pend80_q  <= 1'b0;
            pad_q     <= 1'b0;
            len_blk_q <= 1'b0;
            for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
                blk_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            widx_q    <= widx_d;
            bitcnt_q  <= bitcnt_d;
            final_q   <= final_d;
            pend80_q  <= pend80_d;
            pad_q     <= pad_d;
            len_blk_q <= len_blk_d;
            blk_q     <= blk_d;
        end
    end

endmodule

// File: tb/tb_sha256_padder.sv
// Bench for sha256_padder: directed spec vectors plus randomized messages
// compared against a byte-queue padding model.
module tb_sha256_padder;

    typedef logic [7:0] bytes_t [$];

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic [2:0]   in_bytes = '0;
    logic         in_ready;
    logic [511:0] block_o;
    logic         block_valid_o;
    logic         block_ready_i = 1'b0;
    logic         block_last_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sha256_padder #(.LEN_W(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_last       (in_last),
        .in_bytes      (in_bytes),
        .in_ready      (in_ready),
        .block_o       (block_o),
        .block_valid_o (block_valid_o),
        .block_ready_i (block_ready_i),
        .block_last_o  (block_last_o)
    );

    // Reference: message bytes, 0x80, zeros to 56 mod 64, 8-byte big-endian bit length.
    function automatic bytes_t pad_model(input bytes_t msg);
        bytes_t      q;
        logic [63:0] len;
        q   = msg;
        len = 64'(msg.size()) * 64'd8;
        q.push_back(8'h80);
        while ((q.size() % 64) != 56) q.push_back(8'h00);
        for (int k = 7; k >= 0; k--) q.push_back(len[8*k +: 8]);
        return q;
    endfunction

    function automatic logic [511:0] block_of(input bytes_t q, input int b);
        logic [511:0] r;
        r = '0;
        for (int k = 0; k < 64; k++) r[511-8*k -: 8] = q[64*b+k];
        return r;
    endfunction

    function automatic bytes_t rand_msg(input int n);
        bytes_t q;
        for (int k = 0; k < n; k++) q.push_back(8'($urandom));
        return q;
    endfunction

    // Called at a negedge; returns at the negedge after the word is accepted.
    task automatic drive_word(input logic [31:0] d, input logic lst, input logic [2:0] nb,
                              input int gap, output bit ok);
        ok = 1'b0;
        repeat (gap) @(negedge clk);
        in_data  = d;
        in_last  = lst;
        in_bytes = nb;
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (in_ready) begin
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // mode 0: random encoding, 1: word-aligned end uses in_bytes=4, 2: word-aligned end uses a 0-byte last word
    task automatic send_msg(input bytes_t msg, input int mode, input int max_gap, output bit ok);
        int          n, nfull, rem;
        bit          zero_tail, wok, lst;
        logic [31:0] w;
        logic [2:0]  nb;
        n     = msg.size();
        nfull = n / 4;
        rem   = n % 4;
        ok    = 1'b1;
        if (rem != 0)      zero_tail = 1'b0;
        else if (n == 0)   zero_tail = 1'b1;
        else if (mode == 1) zero_tail = 1'b0;
        else if (mode == 2) zero_tail = 1'b1;
        else               zero_tail = bit'($urandom_range(0, 1));
        for (int j = 0; j < nfull; j++) begin
            w   = {msg[4*j], msg[4*j+1], msg[4*j+2], msg[4*j+3]};
            lst = (rem == 0) && !zero_tail && (j == nfull - 1);
            if (lst && mode == 0 && $urandom_range(0, 2) == 0) nb = 3'($urandom_range(5, 7));
            else if (lst) nb = 3'd4;
            else          nb = 3'($urandom);
            drive_word(w, lst, nb, $urandom_range(0, max_gap), wok);
            if (!wok) ok = 1'b0;
        end
        if (rem != 0 || zero_tail) begin
            w = $urandom;
            for (int k = 0; k < rem; k++) w[31-8*k -: 8] = msg[4*nfull+k];
            drive_word(w, 1'b1, 3'(rem), $urandom_range(0, max_gap), wok);
            if (!wok) ok = 1'b0;
        end
    endtask

    // Waits for a block, stalls, handshakes; reports what it saw.
    task automatic get_block(input int stall, output logic [511:0] blk, output logic lst,
                             output bit proto_ok, output bit ok);
        ok       = 1'b0;
        proto_ok = 1'b1;
        blk      = '0;
        lst      = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (block_valid_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            blk = block_o;
            lst = block_last_o;
            block_ready_i = 1'b0;
            repeat (stall) begin
                @(negedge clk);
                if (block_o !== blk || block_valid_o !== 1'b1 || in_ready !== 1'b0 ||
                    block_last_o !== lst) proto_ok = 1'b0;
            end
            block_ready_i = 1'b1;
            @(negedge clk);
            block_ready_i = 1'b0;
            if (block_valid_o !== 1'b0) proto_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (block_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", block_valid_o); end
        checks++; if (block_last_o !== 1'b0) begin errors++; $display("FAIL reset_last got=%b exp=0", block_last_o); end
        checks++; if (block_o !== 512'h0) begin errors++; $display("FAIL reset_block got=%h exp=0", block_o); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_abc_latency();
        logic [511:0] blk;
        logic         lst;
        bit           pok, ok;
        int           cnt;
        in_data  = 32'h61626300;
        in_last  = 1'b1;
        in_bytes = 3'd3;
        in_valid = 1'b1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abc_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        cnt = 1;
        while (!block_valid_o && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        checks++; if (cnt !== 16) begin errors++; $display("FAIL abc_latency got=%0d exp=16", cnt); end
        get_block(0, blk, lst, pok, ok);
        checks++; if (blk !== {32'h61626380, 448'h0, 32'h00000018}) begin errors++; $display("FAIL abc_block got=%h", blk); end
        checks++; if (lst !== 1'b1) begin errors++; $display("FAIL abc_last got=%b exp=1", lst); end
        checks++; if (!(ok && pok)) begin errors++; $display("FAIL abc_handshake ok=%b proto=%b exp=1/1", ok, pok); end
    endtask

    task automatic test_empty();
        logic [511:0] blk;
        logic         lst;
        bit           pok, ok, sok;
        drive_word($urandom, 1'b1, 3'd0, 0, sok);
        get_block(1, blk, lst, pok, ok);
        checks++; if (!(sok && ok && pok)) begin errors++; $display("FAIL empty_flow send=%b got=%b proto=%b", sok, ok, pok); end
        checks++; if (blk !== {32'h80000000, 480'h0}) begin errors++; $display("FAIL empty_block got=%h", blk); end
        checks++; if (lst !== 1'b1) begin errors++; $display("FAIL empty_last got=%b exp=1", lst); end
    endtask

    task automatic test_56_bytes();
        bytes_t       msg, q;
        logic [511:0] blk;
        logic         lst;
        bit           pok, ok, sok;
        msg = rand_msg(56);
        q   = msg;
        q.push_back(8'h80);
        repeat (7) q.push_back(8'h00);
        send_msg(msg, 1, 1, sok);
        get_block(0, blk, lst, pok, ok);
        checks++; if (blk !== block_of(q, 0)) begin errors++; $display("FAIL b56_blk1 got=%h exp=%h", blk, block_of(q, 0)); end
        checks++; if (lst !== 1'b0) begin errors++; $display("FAIL b56_last1 got=%b exp=0", lst); end
        get_block(0, blk, lst, pok, ok);
        checks++; if (blk !== 512'h1C0) begin errors++; $display("FAIL b56_blk2 got=%h", blk); end
        checks++; if (lst !== 1'b1) begin errors++; $display("FAIL b56_last2 got=%b exp=1", lst); end
        checks++; if (!(sok && ok && pok)) begin errors++; $display("FAIL b56_flow send=%b got=%b proto=%b", sok, ok, pok); end
    endtask

    task automatic test_full_block();
        bytes_t       msg;
        logic [511:0] blk;
        logic         lst;
        bit           pok, ok, sok;
        msg = rand_msg(64);
        send_msg(msg, 1, 0, sok);
        checks++; if (block_valid_o !== 1'b1) begin errors++; $display("FAIL full_latency valid=%b exp=1", block_valid_o); end
        get_block(0, blk, lst, pok, ok);
        checks++; if (blk !== block_of(msg, 0)) begin errors++; $display("FAIL full_blk1 got=%h exp=%h", blk, block_of(msg, 0)); end
        checks++; if (lst !== 1'b0) begin errors++; $display("FAIL full_last1 got=%b exp=0", lst); end
        get_block(0, blk, lst, pok, ok);
        checks++; if (blk !== {32'h80000000, 448'h0, 32'h00000200}) begin errors++; $display("FAIL full_blk2 got=%h", blk); end
        checks++; if (lst !== 1'b1) begin errors++; $display("FAIL full_last2 got=%b exp=1", lst); end
        checks++; if (!(sok && ok && pok)) begin errors++; $display("FAIL full_flow send=%b got=%b proto=%b", sok, ok, pok); end
    endtask

    task automatic test_backpressure();
        bytes_t       msg;
        logic [511:0] blk;
        logic         lst;
        bit           pok, ok, sok;
        msg = rand_msg(64);
        send_msg(msg, 1, 0, sok);
        get_block(10, blk, lst, pok, ok);
        checks++; if (pok !== 1'b1) begin errors++; $display("FAIL bp_stable got=%b exp=1", pok); end
        checks++; if (blk !== block_of(msg, 0)) begin errors++; $display("FAIL bp_blk1 got=%h", blk); end
        get_block(0, blk, lst, pok, ok);
        checks++; if (blk !== block_of(pad_model(msg), 1) || lst !== 1'b1 || !ok) begin
            errors++; $display("FAIL bp_next got=%h last=%b ok=%b", blk, lst, ok);
        end
    endtask

    task automatic test_reset_mid();
        bytes_t       msg;
        logic [511:0] blk;
        logic         lst;
        bit           pok, ok, sok;
        msg = rand_msg(20);
        for (int j = 0; j < 5; j++) drive_word({msg[4*j], msg[4*j+1], msg[4*j+2], msg[4*j+3]}, 1'b0, 3'd0, 0, sok);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0 || block_valid_o !== 1'b0 || block_last_o !== 1'b0 || block_o !== 512'h0) begin
            errors++; $display("FAIL midrst_outputs ready=%b valid=%b last=%b blk=%h exp=0", in_ready, block_valid_o, block_last_o, block_o);
        end
        rst = 1'b1;
        drive_word(32'h61626300, 1'b1, 3'd3, 0, sok);
        get_block(0, blk, lst, pok, ok);
        checks++; if (blk !== {32'h61626380, 448'h0, 32'h00000018} || lst !== 1'b1) begin
            errors++; $display("FAIL midrst_abc got=%h last=%b", blk, lst);
        end
        // Reset while a block is pending.
        send_msg(rand_msg(64), 1, 0, sok);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (block_valid_o !== 1'b0 || block_o !== 512'h0) begin
            errors++; $display("FAIL emitrst_valid valid=%b blk=%h exp=0", block_valid_o, block_o);
        end
        rst = 1'b1;
        drive_word(32'h616263FF, 1'b1, 3'd3, 0, sok);
        get_block(0, blk, lst, pok, ok);
        checks++; if (blk !== {32'h61626380, 448'h0, 32'h00000018} || lst !== 1'b1) begin
            errors++; $display("FAIL emitrst_abc got=%h last=%b", blk, lst);
        end
    endtask

    task automatic test_random();
        int           lens [8] = '{55, 56, 59, 60, 63, 64, 119, 128};
        bytes_t       msg, exp;
        logic [511:0] got  [8];
        logic         glst [8];
        bit           gpok [8];
        bit           gok  [8];
        int           n, nblk;
        bit           sok;
        for (int t = 0; t < 30; t++) begin
            n    = (t < 8) ? lens[t] : int'($urandom_range(0, 200));
            msg  = rand_msg(n);
            exp  = pad_model(msg);
            nblk = exp.size() / 64;
            fork
                send_msg(msg, 0, 2, sok);
                begin
                    for (int b = 0; b < nblk; b++) begin
                        logic [511:0] tb_blk;
                        logic         tb_lst;
                        bit           tb_pok, tb_ok;
                        get_block($urandom_range(0, 3), tb_blk, tb_lst, tb_pok, tb_ok);
                        got[b] = tb_blk; glst[b] = tb_lst; gpok[b] = tb_pok; gok[b] = tb_ok;
                    end
                end
            join
            checks++; if (sok !== 1'b1) begin errors++; $display("FAIL rand_send len=%0d got=%b exp=1", n, sok); end
            for (int b = 0; b < nblk; b++) begin
                checks++;
                if (!gok[b] || !gpok[b] || got[b] !== block_of(exp, b) || glst[b] !== (b == nblk - 1)) begin
                    errors++;
                    $display("FAIL rand_block len=%0d blk=%0d ok=%b proto=%b last=%b got=%h exp=%h",
                             n, b, gok[b], gpok[b], glst[b], got[b], block_of(exp, b));
                end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_abc_latency();
        test_empty();
        test_56_bytes();
        test_full_block();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
